// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int OFFSET_W = 6;
    localparam int INST_W   = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } q_entry_t;

    // Instructions are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_inst_queue.sv
// Circular instruction queue of {pc, inst} entries with a clear that beats push and pop.
module if_inst_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  q_entry_t                 din_i,
    output q_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    q_entry_t          mem_q [DEPTH];
    q_entry_t          last_q;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full && !clear_i;
    assign do_pop  = pop_i && !empty && !clear_i;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (clear_i) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (do_push) begin
                    mem_q[tail_q] <= din_i;
                    tail_q        <= tail_q + 1'b1;
                end
                if (do_pop) begin
                    last_q <= mem_q[head_q];
                    head_q <= head_q + 1'b1;
                end
            end
        end
    end

    // When empty, present the most recently consumed entry so the head is stable.
    assign head_o  = empty ? last_q : mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, L1-I request/stall handling, redirect and fence.i sequencing.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          TNUM     = 21,
    parameter int          INUM     = 26 - TNUM
) (
    input  logic                clk,
    input  logic                rst,
    output logic [TNUM-1:0]     tag_C_L1,
    output logic [INUM-1:0]     index_C_L1,
    output logic [OFFSET_W-1:0] offset,
    output logic                read_C_L1,
    output logic                flush,
    input  logic                stall,
    input  logic [INST_W-1:0]   read_data_L1_C,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                fence_i,
    output logic                inst_valid,
    output logic [INST_W-1:0]   inst,
    output logic [31:0]         inst_pc,
    input  logic                inst_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          pend_fence_q, pend_fence_d;

    logic          rd_req, flush_req, q_push, q_clear, q_pop, q_full, redir;
    logic [31:0]   target;
    logic [CW-1:0] q_count;
    q_entry_t      q_din, q_head;

    assign redir  = redirect_valid || fence_i;
    assign target = align_pc(redirect_pc);
    assign q_full = (q_count == CW'(QDEPTH));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_fence_d = pend_fence_q;
        rd_req       = 1'b0;
        flush_req    = 1'b0;
        q_push       = 1'b0;
        q_clear      = 1'b0;
        case (state_q)
            FETCH: begin
                rd_req = !q_full;
                if (redir) begin
                    q_clear = 1'b1;
                    if (stall) begin
                        pend_pc_d    = target;
                        pend_fence_d = fence_i;
                        state_d      = DROP;
                    end else begin
                        pc_d    = target;
                        state_d = fence_i ? FLUSH : FETCH;
                    end
                end else if (rd_req && !stall) begin
                    q_push = 1'b1;
                    pc_d   = pc_q + 32'd4;
                end
            end
            DROP: begin
                // Keep the in-flight address presented until L1 finishes, then discard it.
                rd_req  = 1'b1;
                q_clear = redir;
                if (!stall) begin
                    pc_d         = redir ? target : pend_pc_q;
                    state_d      = (pend_fence_q || fence_i) ? FLUSH : FETCH;
                    pend_fence_d = 1'b0;
                end else if (redir) begin
                    // A newer target wins, but an earlier fence request is never forgotten.
                    pend_pc_d    = target;
                    pend_fence_d = pend_fence_q || fence_i;
                end
            end
            FLUSH: begin
                flush_req = 1'b1;
                state_d   = FETCH;
                if (redir) begin
                    q_clear = 1'b1;
                    pc_d    = target;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_fence_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_fence_q <= pend_fence_d;
        end
    end

    assign q_din.pc   = pc_q;
    assign q_din.inst = read_data_L1_C;
    assign q_pop      = inst_valid && inst_ready;

    if_inst_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .din_i   (q_din),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Requests are masked while reset is held so the bus is quiet immediately.
    assign read_C_L1  = rd_req && !rst;
    assign flush      = flush_req && !rst;
    assign tag_C_L1   = pc_q[31 -: TNUM];
    assign index_C_L1 = pc_q[OFFSET_W +: INUM];
    assign offset     = pc_q[OFFSET_W-1:0];
    assign inst_valid = (q_count != '0);
    assign inst       = q_head.inst;
    assign inst_pc    = q_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit against a combinational L1-I model (data = addr ^ 0x5A5A0000).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        fence_i = 1'b0;
    logic        inst_ready = 1'b1;
    logic [31:0] redirect_pc = '0;

    logic [20:0] tag;
    logic [4:0]  index;
    logic [5:0]  offset;
    logic        read, flush, inst_valid;
    logic [31:0] inst, inst_pc, addr, rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    assign addr  = {tag, index, offset};
    assign rdata = addr ^ 32'h5A5A_0000;

    if_fetch_unit #(
        .RESET_PC (32'h0000_1000),
        .QDEPTH   (4),
        .TNUM     (21)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tag_C_L1       (tag),
        .index_C_L1     (index),
        .offset         (offset),
        .read_C_L1      (read),
        .flush          (flush),
        .stall          (stall),
        .read_data_L1_C (rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i        (fence_i),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && read && !stall)
            $display("[TB] fetch addr=%h data=%h", addr, rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag_s, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_read", 32'(read), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        rst = 1'b0;
        #1;

        // 1: streaming fetch, one instruction per cycle
        check("t1_addr0", addr, 32'h1000);
        check("t1_read0", 32'(read), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_addr", addr, 32'h1000 + 32'(4 * i));
            check("t1_valid", 32'(inst_valid), 1);
            check("t1_pc", inst_pc, 32'h1000 + 32'(4 * (i - 1)));
            check("t1_inst", inst, (32'h1000 + 32'(4 * (i - 1))) ^ 32'h5A5A_0000);
        end

        // 2: six-cycle stall at 0x1040
        for (int i = 0; i < 40 && addr != 32'h1040; i++) tick();
        check("t2_reach", addr, 32'h1040);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_hold_addr", addr, 32'h1040);
            check("t2_hold_read", 32'(read), 1);
            check("t2_nopush", 32'(inst_valid), 0);
        end
        stall = 1'b0;
        tick();
        check("t2_valid", 32'(inst_valid), 1);
        check("t2_pc", inst_pc, 32'h1040);
        check("t2_inst", inst, 32'h5A5A_1040);
        check("t2_next", addr, 32'h1044);

        // 3: backpressure fills the queue, then drains without loss
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t3_full_read", 32'(read), 0);
        check("t3_full_addr", addr, 32'h1050);
        check("t3_head", inst_pc, 32'h1040);
        tick();
        tick();
        check("t3_hold_read", 32'(read), 0);
        check("t3_hold_addr", addr, 32'h1050);
        inst_ready = 1'b1;
        #1;
        check("t3_no_passthru", 32'(read), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                check("t3_restart", 32'(read), 1);
                check("t3_restart_addr", addr, 32'h1050);
            end
            check("t3_order", inst_pc, 32'h1044 + 32'(4 * i));
        end
        check("t3_addr_end", addr, 32'h1060);

        // 4: redirect while L1 is stalled
        stall = 1'b1;
        tick();
        check("t4_hold", addr, 32'h1060);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("t4_squash", 32'(inst_valid), 0);
        check("t4_old_addr", addr, 32'h1060);
        check("t4_read", 32'(read), 1);
        tick();
        check("t4_old_addr2", addr, 32'h1060);
        stall = 1'b0;
        #1;
        check("t4_drop_addr", addr, 32'h1060);
        tick();
        check("t4_new_addr", addr, 32'h2000);
        check("t4_dropped", 32'(inst_valid), 0);
        tick();
        check("t4_valid", 32'(inst_valid), 1);
        check("t4_pc", inst_pc, 32'h2000);
        check("t4_inst", inst, 32'h5A5A_2000);

        // 5: fence.i with a full queue
        inst_ready = 1'b0;
        #1;
        for (int i = 0; i < 10 && read; i++) tick();
        check("t5_full", 32'(read), 0);
        check("t5_head", inst_pc, 32'h2000);
        fence_i     = 1'b1;
        redirect_pc = 32'h0000_1000;
        tick();
        fence_i     = 1'b0;
        redirect_pc = '0;
        #1;
        check("t5_squash", 32'(inst_valid), 0);
        check("t5_flush", 32'(flush), 1);
        check("t5_noread", 32'(read), 0);
        tick();
        check("t5_flush_once", 32'(flush), 0);
        check("t5_read", 32'(read), 1);
        check("t5_addr", addr, 32'h1000);
        inst_ready = 1'b1;
        tick();
        check("t5_valid", 32'(inst_valid), 1);
        check("t5_pc", inst_pc, 32'h1000);

        // 6: PC wrap, then reset in the middle of a stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("t6_addr0", addr, 32'hFFFF_FFF8);
        check("t6_cleared", 32'(inst_valid), 0);
        tick();
        check("t6_addr1", addr, 32'hFFFF_FFFC);
        check("t6_latency", 32'(inst_valid), 1);
        check("t6_pc1", inst_pc, 32'hFFFF_FFF8);
        tick();
        check("t6_wrap", addr, 32'h0000_0000);
        check("t6_pc2", inst_pc, 32'hFFFF_FFFC);
        check("t6_inst2", inst, 32'hA5A5_FFFC);
        stall = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_read", 32'(read), 0);
        check("t6_rst_flush", 32'(flush), 0);
        check("t6_rst_valid", 32'(inst_valid), 0);
        check("t6_rst_inst", inst, 0);
        check("t6_rst_pc", inst_pc, 0);
        check("t6_rst_addr", addr, 32'h1000);
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        check("t6_restart_read", 32'(read), 1);
        check("t6_restart_addr", addr, 32'h1000);
        tick();
        check("t6_restart_valid", 32'(inst_valid), 1);
        check("t6_restart_pc", inst_pc, 32'h1000);
        check("t6_restart_inst", inst, 32'h5A5A_1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
